// File: rtl/enigma_pkg.sv
// rtl/enigma_pkg.sv - shared Enigma letter type, alphabet constants and rotor I inverse wiring
package enigma_pkg;

    typedef logic [4:0] letter_t;

    localparam int      ALPHA_LEN  = 26;
    localparam letter_t MAX_LETTER = 5'd25;
    localparam letter_t BAD_LETTER = 5'd31;

    // Rotor I wiring seen from the reflector side: "UWYGADFPVZBECKMTHXSLRINQOJ"
    localparam letter_t ROTOR1_INV [0:25] = '{
        5'd20, 5'd22, 5'd24, 5'd6,  5'd0,  5'd3,  5'd5,  5'd15, 5'd21,
        5'd25, 5'd1,  5'd4,  5'd2,  5'd10, 5'd12, 5'd19, 5'd7,  5'd23,
        5'd18, 5'd11, 5'd17, 5'd8,  5'd13, 5'd16, 5'd14, 5'd9
    };

    // Out-of-range indices read as 0; the caller flags those cases separately.
    function automatic letter_t rotor1_inv(input letter_t idx);
        if (idx <= MAX_LETTER)
            return ROTOR1_INV[idx];
        else
            return '0;
    endfunction

endpackage

// File: rtl/mod26_add.sv
// rtl/mod26_add.sv - letter add/subtract with mod-26 wrap (one conditional correction)
module mod26_add
    import enigma_pkg::*;
(
    input  letter_t a_i,
    input  letter_t b_i,
    input  logic    sub_i,
    output letter_t y_o
);

    localparam logic [5:0] LEN6 = 6'(ALPHA_LEN);

    logic [5:0] sum;
    logic [5:0] diff;

    always_comb begin
        sum  = {1'b0, a_i} + {1'b0, b_i};
        diff = {1'b0, a_i} - {1'b0, b_i};
        y_o  = '0;
        if (sub_i) begin
            // A borrow wraps diff mod 64, so adding 26 still lands in 0..25.
            y_o = (a_i < b_i) ? 5'(diff + LEN6) : 5'(diff);
        end else begin
            y_o = (sum >= LEN6) ? 5'(sum - LEN6) : 5'(sum);
        end
    end

endmodule

// File: rtl/reverse_rotor0.sv
// rtl/reverse_rotor0.sv - rotor I return-path substitution, 1-cycle registered; REVERSE_ROTOR0_RING_EN adds ring port
module reverse_rotor0
    import enigma_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [4:0] data_in,
    input  logic [4:0] position,
    output logic [4:0] data_out,
    output logic       out_valid,
    output logic       err
`ifdef REVERSE_ROTOR0_RING_EN
    ,
    input  logic [4:0] ring
`endif
);

    letter_t off;
    letter_t idx;
    letter_t res;
    logic    range_bad;

`ifdef REVERSE_ROTOR0_RING_EN
    mod26_add u_ring (
        .a_i   (position),
        .b_i   (ring),
        .sub_i (1'b1),
        .y_o   (off)
    );
    assign range_bad = (data_in > MAX_LETTER) || (position > MAX_LETTER) ||
                       (ring > MAX_LETTER);
`else
    assign off       = position;
    assign range_bad = (data_in > MAX_LETTER) || (position > MAX_LETTER);
`endif

    mod26_add u_entry (
        .a_i   (data_in),
        .b_i   (off),
        .sub_i (1'b0),
        .y_o   (idx)
    );

    mod26_add u_exit (
        .a_i   (rotor1_inv(idx)),
        .b_i   (off),
        .sub_i (1'b1),
        .y_o   (res)
    );

    letter_t data_q, data_d;
    logic    valid_q, valid_d;
    logic    err_q, err_d;

    always_comb begin
        valid_d = 1'b0;
        data_d  = data_q;
        err_d   = err_q;
        if (in_valid) begin
            valid_d = 1'b1;
            if (range_bad) begin
                data_d = BAD_LETTER;
                err_d  = 1'b1;
            end else begin
                data_d = res;
                err_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign data_out  = data_q;
    assign out_valid = valid_q;
    assign err       = err_q;

endmodule

// File: tb/tb_reverse_rotor0.sv
// tb/tb_reverse_rotor0.sv - randomized bench with a modular-arithmetic reference model for reverse_rotor0
module tb_reverse_rotor0;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [4:0] data_in = '0;
    logic [4:0] position = '0;
    logic [4:0] ring = '0;
    logic [4:0] data_out;
    logic       out_valid;
    logic       err;

    int total = 0;
    int bad   = 0;
    int inv [26];
    bit chk_en = 1'b0;

    int m_data  = 0;
    int m_valid = 0;
    int m_err   = 0;

    always #5 clk = ~clk;

    reverse_rotor0 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .data_in   (data_in),
        .position  (position),
        .data_out  (data_out),
        .out_valid (out_valid),
        .err       (err)
`ifdef REVERSE_ROTOR0_RING_EN
        ,
        .ring      (ring)
`endif
    );

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int ring_eff(input int r);
`ifdef REVERSE_ROTOR0_RING_EN
        return r;
`else
        return 0;
`endif
    endfunction

    function automatic int ref_out(input int d, input int p, input int r);
        int o;
        int k;
        o = ((p - r) % 26 + 26) % 26;
        k = (d + o) % 26;
        return ((inv[k] - o) % 26 + 26) % 26;
    endfunction

    // Reference: what the output register must hold after each rising edge.
    always @(posedge clk) begin
        if (rst) begin
            m_data  <= 0;
            m_valid <= 0;
            m_err   <= 0;
        end else if (in_valid) begin
            m_valid <= 1;
            if (data_in > 25 || position > 25 || ring_eff(ring) > 25) begin
                m_data <= 31;
                m_err  <= 1;
            end else begin
                m_data <= ref_out(data_in, position, ring_eff(ring));
                m_err  <= 0;
            end
        end else begin
            m_valid <= 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_valid", out_valid, m_valid);
            check("model_data", data_out, m_data);
            check("model_err", err, m_err);
        end
    end

    // Present one letter for one cycle, then check the registered result literally.
    task automatic one(input string name, input int d, input int p, input int r,
                       input int exp_d, input int exp_e);
        @(negedge clk);
        data_in  = 5'(d);
        position = 5'(p);
        ring     = 5'(r);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check({name, "_valid"}, out_valid, 1);
        check({name, "_data"}, data_out, exp_d);
        check({name, "_err"}, err, exp_e);
    endtask

    initial begin
        string wiring;
        wiring = "UWYGADFPVZBECKMTHXSLRINQOJ";
        for (int i = 0; i < 26; i++) inv[i] = int'(wiring[i]) - int'("A");

        // Reset dominates in_valid
        rst = 1'b1;
        in_valid = 1'b1;
        data_in = 5'd7;
        position = 5'd3;
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        check("reset_valid", out_valid, 0);
        check("reset_data", data_out, 0);
        check("reset_err", err, 0);
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("idle_valid", out_valid, 0);

        one("basic", 13, 1, 0, 11, 0);
        one("pos0_a", 0, 0, 0, 20, 0);
        one("pos0_e", 4, 0, 0, 0, 0);
        one("wrap_sum", 25, 1, 0, 19, 0);
        one("wrap_sub", 0, 25, 0, 10, 0);
`ifdef REVERSE_ROTOR0_RING_EN
        one("ring", 13, 1, 1, 10, 0);
        one("ring_bad", 3, 3, 26, 31, 1);
`endif
        ring = '0;

        // Back-to-back stream of every letter at position 0
        for (int i = 0; i <= 26; i++) begin
            @(negedge clk);
            if (i > 0) begin
                check("stream_valid", out_valid, 1);
                check("stream_data", data_out, inv[i-1]);
            end
            if (i < 26) begin
                data_in  = 5'(i);
                position = 5'd0;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
        end

        one("range_data", 26, 0, 0, 31, 1);
        @(negedge clk);
        check("hold_valid", out_valid, 0);
        check("hold_data", data_out, 31);
        check("hold_err", err, 1);
        one("range_pos", 4, 30, 0, 31, 1);
        one("recover", 13, 1, 0, 11, 0);

        // Reset arriving with a letter in flight discards it
        @(negedge clk);
        data_in = 5'd5;
        position = 5'd2;
        in_valid = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        check("midrst_valid", out_valid, 0);
        check("midrst_data", data_out, 0);

        // Random traffic, mostly in range, with occasional resets
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            in_valid = ($urandom_range(0, 3) != 0);
            data_in  = ($urandom_range(0, 15) == 0) ? 5'($urandom_range(26, 31))
                                                    : 5'($urandom_range(0, 25));
            position = ($urandom_range(0, 15) == 0) ? 5'($urandom_range(26, 31))
                                                    : 5'($urandom_range(0, 25));
            ring     = ($urandom_range(0, 15) == 0) ? 5'($urandom_range(26, 31))
                                                    : 5'($urandom_range(0, 25));
            rst      = ($urandom_range(0, 99) == 0);
        end
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reverse_rotor0.md
Name: reverse_rotor0

Overview:
- Return-path (right-to-left) substitution stage of Enigma rotor I, for the cipher datapath after the reflector.
- Maps a 5-bit letter index (A=0 … Z=25) through the inverse rotor-I wiring, offset by the current rotor position.
- Output is registered with 1-cycle latency and a valid strobe.

Parameters:
- none (wiring is fixed to rotor I; position and ring offsets are ports)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous active-high reset
- in_valid  input  1  data_in/position qualify this cycle
- data_in  input  5  letter index entering from the reflector side, 0–25
- position  input  5  rotor position (Grundstellung after stepping), 0–25
- data_out  output  5  substituted letter index toward the next rotor
- out_valid  output  1  data_out valid this cycle
- err  output  1  registered flag: the accepted inputs were out of range

Behaviour:
- Inverse wiring table INV[0..25] = "UWYGADFPVZBECKMTHXSLRINQOJ" as indices: 20,22,24,6,0,3,5,15,21,25,1,4,2,10,12,19,7,23,18,11,17,8,13,16,14,9.
- Combinational core:
  - idx = (data_in + position) mod 26
  - res = (INV[idx] − position) mod 26
  - Both mod-26 operations use 6-bit intermediates with a single conditional ±26 correction. No divider.
- Register stage, on the rising edge of clk:
  - rst=1: data_out=0, out_valid=0, err=0. Reset wins over in_valid.
  - else if in_valid=1: out_valid=1.
    - If data_in>25 or position>25: data_out=31, err=1.
    - Otherwise: data_out=res, err=0.
  - else: out_valid=0; data_out and err hold their previous values.
- Latency: exactly 1 cycle from in_valid to out_valid.
- Throughput: one letter per cycle, with back-to-back in_valid supported. No backpressure.
- Boundary cases:
  - data_in+position ≥ 26 wraps.
  - INV[idx] < position wraps by +26.
  - position=0 gives the pure inverse wiring.
- Reset asserted mid-stream discards the value in flight.

Optional Feature:
- Macro REVERSE_ROTOR0_RING_EN.
- Defined:
  - Adds input port ring [4:0] (Ringstellung, 0–25).
  - Effective offset off = (position − ring) mod 26 replaces position in both equations.
  - ring>25 is treated as out of range, giving data_out=31 and err=1.
- Undefined:
  - No ring port; off = position.
  - Behaviour exactly as above.

Decomposition:
- Shared package enigma_pkg holds:
  - letter_t (logic [4:0])
  - constant ALPHA_LEN=26
  - constant BAD_LETTER=5'd31
  - the rotor I inverse table ROTOR1_INV as a constant array, reusable by other rotor stages.
- One natural sub-module, mod26_add: a 5-bit add/subtract with mod-26 wrap and select input. Two instances: the entry offset and the exit offset.

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=1 → data_out=0, out_valid=0, err=0; after release, in_valid=0 → out_valid stays 0.
- Basic offset: data_in=13, position=1, in_valid pulse → one cycle later data_out=11 (L), out_valid=1, err=0.
- Zero position: data_in=0, position=0 → 20. Then data_in=4, position=0 → 0.
- Wrap cases, all pass with err=0:
  - data_in=25, position=1 → 19
  - data_in=0, position=25 → 10
- Streaming and range checks:
  - Back-to-back in_valid over all 26 data_in with position=0 → outputs follow INV in order, one per cycle.
  - data_in=26 → data_out=31, err=1.
- Ring feature (REVERSE_ROTOR0_RING_EN): data_in=13, position=1, ring=1 → data_out=10. With the macro undefined, the same stimulus without ring → 11.
